// File: rtl/mul_vector_seq.sv
// Sequential limb-vector multiplier: one LIMB_W x LIMB_W partial product per cycle.
// Define MUL_VECTOR_SEQ_ROW_EN to add a whole operand row per cycle instead.
module mul_vector_seq #(
  parameter int LIMB_W    = 16,
  parameter int NUM_LIMBS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LIMBS*LIMB_W-1:0]     a,
  input  logic [NUM_LIMBS*LIMB_W-1:0]     b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*NUM_LIMBS*LIMB_W-1:0]   y,
  output logic                            busy
);

  localparam int OPW = NUM_LIMBS * LIMB_W;
  localparam int YW  = 2 * OPW;
  localparam int IW  = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_LIMBS - 1);

  if (NUM_LIMBS < 1 || LIMB_W < 1) begin : g_bad_params
    $error("mul_vector_seq: NUM_LIMBS and LIMB_W must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic [OPW-1:0]  a_q, b_q;
  logic [YW-1:0]   acc, y_q, term, sum;
  logic [IW-1:0]   j_q;
  logic [LIMB_W-1:0] b_limb;
  logic            last_step;

  assign b_limb = LIMB_W'(b_q >> (32'(j_q) * LIMB_W));

`ifdef MUL_VECTOR_SEQ_ROW_EN
  logic [OPW+LIMB_W-1:0] row;

  // Whole row A * b_j lands at limb offset j; the last row finishes the product.
  always_comb begin
    row       = (OPW+LIMB_W)'(a_q) * (OPW+LIMB_W)'(b_limb);
    term      = YW'(row) << (32'(j_q) * LIMB_W);
    last_step = (j_q == LAST);
  end
`else
  logic [IW-1:0]       i_q;
  logic [LIMB_W-1:0]   a_limb;
  logic [2*LIMB_W-1:0] pp;

  // Single partial product a_i * b_j lands at limb offset i+j.
  always_comb begin
    a_limb    = LIMB_W'(a_q >> (32'(i_q) * LIMB_W));
    pp        = (2*LIMB_W)'(a_limb) * (2*LIMB_W)'(b_limb);
    term      = YW'(pp) << ((32'(i_q) + 32'(j_q)) * LIMB_W);
    last_step = (i_q == LAST) && (j_q == LAST);
  end
`endif

  assign sum = acc + term;
  assign y   = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept so later input changes cannot disturb the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      y_q <= '0;
      j_q <= '0;
`ifndef MUL_VECTOR_SEQ_ROW_EN
      i_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            j_q <= '0;
`ifndef MUL_VECTOR_SEQ_ROW_EN
            i_q <= '0;
`endif
          end
        end
        MUL: begin
          acc <= sum;
          if (last_step) y_q <= sum;
          if (j_q == LAST) begin
            j_q <= '0;
`ifndef MUL_VECTOR_SEQ_ROW_EN
            i_q <= i_q + 1'b1;
`endif
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_vector_seq.sv
// Scoreboard bench for mul_vector_seq: expected products are queued at accept
// and compared when the product is presented.
module tb_mul_vector_seq;

  localparam int LIMB_W    = 16;
  localparam int NUM_LIMBS = 2;
  localparam int OPW       = NUM_LIMBS * LIMB_W;
  localparam int YW        = 2 * OPW;
`ifdef MUL_VECTOR_SEQ_ROW_EN
  localparam int LAT = NUM_LIMBS;
`else
  localparam int LAT = NUM_LIMBS * NUM_LIMBS;
`endif
  localparam int TIMEOUT = 50;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] a = '0;
  logic [OPW-1:0] b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [YW-1:0]  y;
  logic           busy;

  int tests = 0;
  int failures = 0;
  logic [YW-1:0] exp_q[$];

  mul_vector_seq #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [YW-1:0] observed,
                             input logic [YW-1:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one accepted operand pair; returns just after the accept edge.
  task automatic applyStimulus(input logic [OPW-1:0] av, input logic [OPW-1:0] bv);
    @(negedge clk);
    checkOutput("in_ready_before_accept", YW'(in_ready), YW'(1));
    a = av;
    b = bv;
    in_valid = 1'b1;
    exp_q.push_back(YW'(av) * YW'(bv));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency from accept and pop/compare the product.
  task automatic waitResult(input string tag);
    int n = 0;
    logic [YW-1:0] expv;
    while (!out_valid && n < TIMEOUT) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput({tag, "_latency"}, YW'(n), YW'(LAT));
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, YW'(1), YW'(0));
    end else begin
      expv = exp_q.pop_front();
      checkOutput({tag, "_y"}, y, expv);
    end
  endtask

  task automatic consume(input string tag);
    logic [YW-1:0] held;
    held = y;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_in_ready_after"}, YW'(in_ready), YW'(1));
    checkOutput({tag, "_out_valid_after"}, YW'(out_valid), YW'(0));
    checkOutput({tag, "_y_kept"}, y, held);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [YW-1:0] held;
    logic [OPW-1:0] ra, rb;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", YW'(in_ready), YW'(1));
    checkOutput("rst_out_valid", YW'(out_valid), YW'(0));
    checkOutput("rst_y", y, '0);
    checkOutput("rst_busy", YW'(busy), YW'(0));

    // Basic product, also against the literal value
    applyStimulus(32'h0001_0002, 32'h0003_0004);
    checkOutput("basic_busy", YW'(busy), YW'(1));
    checkOutput("basic_in_ready_busy", YW'(in_ready), YW'(0));
    waitResult("basic");
    checkOutput("basic_literal", y, 64'h0000_0003_000A_0008);
    consume("basic");

    // Max operands, inputs scrambled during MUL
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    a = 32'h0000_0000;
    b = 32'h1234_5678;
    waitResult("max");
    checkOutput("max_literal", y, 64'hFFFF_FFFE_0000_0001);
    consume("max");

    // Zero operands with out_ready already high: full latency, one-cycle output
    @(negedge clk) out_ready = 1'b1;
    applyStimulus('0, '0);
    waitResult("zero");
    consume("zero");

    // Backpressure: product held, new requests ignored
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    waitResult("bp");
    held = y;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h0000_0003;
      b = 32'h0000_0003;
      @(posedge clk);
      #1;
      checkOutput("bp_y_stable", y, held);
      checkOutput("bp_in_ready", YW'(in_ready), YW'(0));
      checkOutput("bp_out_valid", YW'(out_valid), YW'(1));
    end
    @(negedge clk) in_valid = 1'b0;
    consume("bp");
    repeat (3) begin
      @(posedge clk);
      #1 checkOutput("bp_no_ghost_busy", YW'(busy), YW'(0));
    end

    // Reset mid-MUL aborts with no output
    applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", YW'(out_valid), YW'(0));
    checkOutput("abort_y", y, '0);
    checkOutput("abort_busy", YW'(busy), YW'(0));
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(32'h0000_0005, 32'h0000_0007);
    waitResult("post_abort");
    checkOutput("post_abort_literal", y, 64'h23);
    consume("post_abort");

    // Random operands with random consumer delay
    for (int t = 0; t < 1000; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 7 == 0) ra = '1;
      if (t % 11 == 0) rb = '0;
      applyStimulus(ra, rb);
      waitResult("rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 checkOutput("rand_hold", YW'(out_valid), YW'(1));
      consume("rand");
    end

    checkOutput("scoreboard_drained", YW'(exp_q.size()), YW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
